keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 50_000, meaning clk cycles each row is driven (row dwell), legal range >= 2.
REQ-002 The block SHALL have parameter DEB_FRAMES, default 4, meaning consecutive identical scan frames needed to accept a press or a release, legal range >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, all logic on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low; clock clk.
REQ-005 The block SHALL have port row, output, 4 bits: keypad row drive, active-low, exactly one bit low at any time.
REQ-006 The block SHALL have port col, input, 3 bits: keypad column sense, active-low (externally pulled up), asynchronous to clk.
REQ-007 The block SHALL have port key_a, output, 10 bits: one-hot digit strobe, bit n pulses for digit n.
REQ-008 The block SHALL have port key_sure, output, 1 bit: strobe for '#'.
REQ-009 The block SHALL have port key_clear, output, 1 bit: strobe for '*'.
REQ-010 The block SHALL have port key_code, output, 4 bits: code of last accepted key (0-9 digits, 4'hA '*', 4'hB '#').
REQ-011 The block SHALL have port key_valid, output, 1 bit: single-cycle strobe marking acceptance of a key.
REQ-012 The block SHALL have port key_held, output, 1 bit: high while an accepted key is not yet debounced-released.

Function
REQ-013 Keymap SHALL be row0 = 1 2 3, row1 = 4 5 6, row2 = 7 8 9, row3 = * 0 #, with col0 leftmost.
REQ-014 Row SHALL advance every CLK_DIV cycles in the order 1110 -> 1101 -> 1011 -> 0111 -> 1110, so one frame = 4*CLK_DIV cycles.
REQ-015 Col SHALL pass a 2-flop synchronizer, then be sampled on the last cycle of each row dwell.
REQ-016 Frame result SHALL be evaluated at the row3 sample: EMPTY if 0 keys are low, SINGLE(code) if exactly 1 is low, MULTI if 2 or more are low.
REQ-017 FSM states SHALL be IDLE, CAND, PRESSED, REL.
REQ-018 IDLE: SINGLE(c) -> CAND with cand = c and cnt = 1; EMPTY or MULTI -> stay.
REQ-019 CAND: SINGLE(cand) -> cnt + 1; SINGLE(other) -> restart with the new code and cnt = 1; EMPTY or MULTI -> IDLE.
REQ-020 On reaching cnt == DEB_FRAMES, the FSM SHALL go to PRESSED, latch key_code, and assert key_valid plus exactly one of key_a[n], key_sure or key_clear for one cycle, the cycle after the evaluation.
REQ-021 PRESSED: EMPTY -> REL with cnt = 1; SINGLE (any code) or MULTI -> stay. There SHALL be no auto-repeat.
REQ-022 REL: EMPTY -> cnt + 1, and at DEB_FRAMES -> IDLE; SINGLE or MULTI -> PRESSED.
REQ-023 key_held SHALL be high in PRESSED and REL.
REQ-024 A new key pressed while in PRESSED SHALL NOT be reported until a full debounced release occurs.
REQ-025 Divider counter SHALL be $clog2(CLK_DIV) bits, wrapping at CLK_DIV-1; debounce counter SHALL be $clog2(DEB_FRAMES+1) bits and saturate at DEB_FRAMES.
REQ-026 DEB_FRAMES = 1 SHALL accept a press on the first SINGLE frame.

Reset
REQ-027 While rst is low, outputs SHALL be row = 4'b1110, key_a = 0, key_sure = key_clear = key_valid = key_held = 0, key_code = 0.
REQ-028 While rst is low, state SHALL be IDLE and all counters and synchronizers SHALL be 0.
REQ-029 Reset mid-press SHALL discard the candidate, emit no strobe, and restart the scan at row0 with the first frame after release.

Structure
REQ-030 Shared package keypad_pkg SHALL hold the FSM state encoding, key code constants (KEY_STAR = 4'hA, KEY_HASH = 4'hB) and the row/col-to-code map.
REQ-031 Sub-module key_frame_scan SHALL contain the row driver, divider, col synchronizer and frame accumulation, and SHALL output frame_done, frame_type and frame_code; the FSM and strobes SHALL stay in keypad_scanner.

Verification
REQ-032 Bench SHALL use CLK_DIV = 4 and DEB_FRAMES = 2 (frame = 16 cycles) for all scenarios below.
REQ-033 Hold key '5' (col1 low during row1) for 5 frames -> exactly one key_valid with key_a = 10'b0000100000 and key_code = 5, issued after the second frame; key_held drops after 2 empty frames.
REQ-034 Hold '#' for 3 frames -> key_sure pulses once, key_code = 4'hB, key_a stays 0.
REQ-035 Bounce '8' present in 1 frame, absent in 1, present in 1, absent thereafter -> no strobe.
REQ-036 Hold '1' and '3' together for 4 frames -> no strobe; then release '3' while holding '1' for 2 frames -> key_a[1] pulses once.
REQ-037 Press '2', then without a clean release switch to '9' -> only '2' is reported; '9' is reported only after 2 empty frames and a fresh 2-frame press.
REQ-038 Assert rst low after 1 frame of '0' held -> all outputs return to reset values with no strobe, and row = 1110 within 1 cycle.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x3 keypad scanner: FSM states, frame classes,
// special key codes and the row/column to key-code map.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAND,
        PRESSED,
        REL
    } kp_state_e;

    typedef enum logic [1:0] {
        FRAME_EMPTY,
        FRAME_SINGLE,
        FRAME_MULTI
    } frame_type_e;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;
    localparam int         NUM_ROWS = 4;
    localparam int         NUM_COLS = 3;

    // Rows 0-2 hold digits 1-9 left to right; row 3 is '*', '0', '#'.
    function automatic logic [3:0] key_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [3:0] code;
        if (row_idx == 2'd3) begin
            case (col_idx)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = 4'(row_idx) * 4'd3 + 4'(col_idx) + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_frame_scan.sv
// Row driver, row-dwell divider, column synchronizer and per-frame key
// accumulation; reports one classified frame result per full 4-row scan.
module key_frame_scan
    import keypad_pkg::*;
#(
    parameter int CLK_DIV = 50_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  col,
    output logic [3:0]  row,
    output logic        frame_done,
    output frame_type_e frame_type,
    output logic [3:0]  frame_code
);

    localparam int             DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [1:0]       hits_q, hits_d;
    logic [3:0]       code_q, code_d;
    logic             frame_done_q, frame_done_d;
    frame_type_e      frame_type_q, frame_type_d;
    logic [3:0]       frame_code_q, frame_code_d;

    logic [1:0] row_hits;
    logic [3:0] row_code;
    logic [1:0] base_hits;
    logic [2:0] total_hits;

    always_comb begin
        div_d        = div_q + 1'b1;
        row_idx_d    = row_idx_q;
        sync1_d      = col;
        sync2_d      = sync1_q;
        hits_d       = hits_q;
        code_d       = code_q;
        frame_done_d = 1'b0;
        frame_type_d = frame_type_q;
        frame_code_d = frame_code_q;

        row_hits = 2'd0;
        row_code = 4'd0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (!sync2_q[c]) begin
                row_hits = row_hits + 2'd1;
                row_code = key_map(row_idx_q, 2'(c));
            end
        end

        // Row 0 starts a fresh frame; the hit count saturates at 2 (= MULTI).
        base_hits  = (row_idx_q == 2'd0) ? 2'd0 : hits_q;
        total_hits = {1'b0, base_hits} + {1'b0, row_hits};

        if (div_q == DIV_LAST) begin
            div_d     = '0;
            row_idx_d = row_idx_q + 2'd1;
            hits_d    = (total_hits >= 3'd2) ? 2'd2 : total_hits[1:0];
            if (row_hits == 2'd1) begin
                code_d = row_code;
            end
            if (row_idx_q == 2'd3) begin
                frame_done_d = 1'b1;
                frame_code_d = code_d;
                if (total_hits == 3'd0) begin
                    frame_type_d = FRAME_EMPTY;
                end else if (total_hits == 3'd1) begin
                    frame_type_d = FRAME_SINGLE;
                end else begin
                    frame_type_d = FRAME_MULTI;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q        <= '0;
            row_idx_q    <= 2'd0;
            sync1_q      <= 3'd0;
            sync2_q      <= 3'd0;
            hits_q       <= 2'd0;
            code_q       <= 4'd0;
            frame_done_q <= 1'b0;
            frame_type_q <= FRAME_EMPTY;
            frame_code_q <= 4'd0;
        end else begin
            div_q        <= div_d;
            row_idx_q    <= row_idx_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            hits_q       <= hits_d;
            code_q       <= code_d;
            frame_done_q <= frame_done_d;
            frame_type_q <= frame_type_d;
            frame_code_q <= frame_code_d;
        end
    end

    assign row        = ~(4'b0001 << row_idx_q);
    assign frame_done = frame_done_q;
    assign frame_type = frame_type_q;
    assign frame_code = frame_code_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner top: debounce FSM over scan frames and key strobes.
// A key is reported once per debounced press; no auto-repeat.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_DIV    = 50_000,
    parameter int DEB_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row,
    input  logic [2:0] col,
    output logic [9:0] key_a,
    output logic       key_sure,
    output logic       key_clear,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int               CNT_W   = $clog2(DEB_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic        frame_done;
    frame_type_e frame_type;
    logic [3:0]  frame_code;

    key_frame_scan #(
        .CLK_DIV(CLK_DIV)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .col        (col),
        .row        (row),
        .frame_done (frame_done),
        .frame_type (frame_type),
        .frame_code (frame_code)
    );

    kp_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic [9:0]       key_a_q, key_a_d;
    logic             key_sure_q, key_sure_d;
    logic             key_clear_q, key_clear_d;
    logic             accept;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        accept      = 1'b0;
        cnt_inc     = (cnt_q < CNT_MAX) ? cnt_q + CNT_ONE : cnt_q;

        if (frame_done) begin
            unique case (state_q)
                IDLE: begin
                    if (frame_type == FRAME_SINGLE) begin
                        cand_d  = frame_code;
                        cnt_d   = CNT_ONE;
                        state_d = CAND;
                        accept  = (CNT_ONE >= CNT_MAX);
                    end
                end
                CAND: begin
                    if (frame_type == FRAME_SINGLE && frame_code == cand_q) begin
                        cnt_d  = cnt_inc;
                        accept = (cnt_inc >= CNT_MAX);
                    end else if (frame_type == FRAME_SINGLE) begin
                        cand_d = frame_code;
                        cnt_d  = CNT_ONE;
                        accept = (CNT_ONE >= CNT_MAX);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                PRESSED: begin
                    // Only an empty frame starts a release; other keys are ignored.
                    if (frame_type == FRAME_EMPTY) begin
                        if (CNT_ONE >= CNT_MAX) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = REL;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                REL: begin
                    if (frame_type == FRAME_EMPTY) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CNT_MAX) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (accept) begin
            state_d    = PRESSED;
            cnt_d      = '0;
            key_code_d = cand_d;
        end

        key_valid_d = accept;
        key_a_d     = 10'd0;
        key_sure_d  = 1'b0;
        key_clear_d = 1'b0;
        if (accept) begin
            if (cand_d == KEY_HASH) begin
                key_sure_d = 1'b1;
            end else if (cand_d == KEY_STAR) begin
                key_clear_d = 1'b1;
            end else begin
                key_a_d = 10'b1 << cand_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_a_q     <= 10'd0;
            key_sure_q  <= 1'b0;
            key_clear_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_a_q     <= key_a_d;
            key_sure_q  <= key_sure_d;
            key_clear_q <= key_clear_d;
        end
    end

    assign key_a     = key_a_q;
    assign key_sure  = key_sure_q;
    assign key_clear = key_clear_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = (state_q == PRESSED) || (state_q == REL);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: simulated keypad matrix, directed scenario table,
// random frames against a run-length reference model, and reset mid-press.
module tb_keypad_scanner;

    localparam int CLK_DIV = 4;
    localparam int DEB     = 2;
    localparam int FRAME   = 4 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row;
    logic [2:0] col;
    logic [9:0] key_a;
    logic       key_sure, key_clear, key_valid, key_held;
    logic [3:0] key_code;

    // Key mask bit index = row*3 + col.
    logic [11:0] keys = 12'd0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .CLK_DIV    (CLK_DIV),
        .DEB_FRAMES (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_a     (key_a),
        .key_sure  (key_sure),
        .key_clear (key_clear),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always_comb begin
        col = 3'b111;
        for (int r = 0; r < 4; r++) begin
            if (!row[r]) begin
                for (int c = 0; c < 3; c++) begin
                    if (keys[r*3+c]) col[c] = 1'b0;
                end
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [3:0] idx2code(input int i);
        if (i < 9)   return 4'(i + 1);
        if (i == 9)  return 4'hA;
        if (i == 10) return 4'h0;
        return 4'hB;
    endfunction

    function automatic logic [11:0] kmask(input int i);
        logic [11:0] one;
        one = 12'd1;
        return one << i;
    endfunction

    // Strobe monitor: every strobe must match the latched key code.
    logic [3:0] obs_q[$];
    int         ev_total = 0;
    logic [3:0] ev_last  = 4'd0;

    always @(negedge clk) begin
        logic [11:0] exp_bits;
        if (rst && (key_valid || key_sure || key_clear || key_a != 10'd0)) begin
            exp_bits = 12'd0;
            if (key_code == 4'hB)      exp_bits[1] = 1'b1;
            else if (key_code == 4'hA) exp_bits[0] = 1'b1;
            else                       exp_bits[2 + key_code] = 1'b1;
            check("strobe_valid", 32'(key_valid), 32'd1);
            check("strobe_bits", 32'({key_a, key_sure, key_clear}), 32'(exp_bits));
            obs_q.push_back(key_code);
            ev_total++;
            ev_last = key_code;
        end
    end

    // Reference model: a key is reported after DEB consecutive frames with that
    // single key while unlocked; DEB consecutive empty frames unlock again.
    bit         locked    = 1'b0;
    int         run       = 0;
    logic [3:0] run_code  = 4'd0;
    int         empty_run = 0;
    logic [3:0] exp_q[$];

    task automatic model_reset();
        locked = 1'b0; run = 0; empty_run = 0; run_code = 4'd0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic [11:0] m);
        int         n;
        logic [3:0] code;
        n = $countones(m);
        code = 4'd0;
        for (int i = 11; i >= 0; i--) if (m[i]) code = idx2code(i);
        if (locked) begin
            if (n == 0) begin
                empty_run++;
                if (empty_run >= DEB) begin locked = 1'b0; run = 0; end
            end else begin
                empty_run = 0;
            end
        end else if (n == 1) begin
            if (run > 0 && code == run_code) run++;
            else begin run = 1; run_code = code; end
            if (run >= DEB) begin
                exp_q.push_back(code);
                locked = 1'b1; empty_run = 0; run = 0;
            end
        end else begin
            run = 0;
        end
    endtask

    // One scan frame with mask m, entered at the negedge of the frame's cycle 0.
    // The previous frame's decision is visible from cycle 1, checked at cycle 2.
    task automatic frame(input logic [11:0] m);
        int n;
        keys = m;
        repeat (2) @(negedge clk);
        check("event_count", 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check("event_code", 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
        check("key_held", 32'(key_held), 32'(locked));
        model_step(m);
        repeat (FRAME - 2) @(negedge clk);
    endtask

    // Empty frame straight after reset release, checking the row rotation.
    task automatic row_frame();
        logic [3:0] exp_row;
        keys = 12'd0;
        for (int i = 0; i < FRAME; i++) begin
            exp_row = ~(4'b0001 << (i / CLK_DIV));
            check("row_seq", 32'(row), 32'(exp_row));
            @(negedge clk);
        end
        model_step(12'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row"},   32'(row),       32'hE);
        check({tag, "_key_a"}, 32'(key_a),     32'd0);
        check({tag, "_flags"}, 32'({key_sure, key_clear, key_valid, key_held}), 32'd0);
        check({tag, "_code"},  32'(key_code),  32'd0);
    endtask

    typedef struct {
        int           nfr;
        logic [191:0] masks;
        int           exp_n;
        logic [3:0]   exp_code;
    } vec_t;

    vec_t tbl [5];

    task automatic add(input int v, input logic [11:0] m, input int count);
        for (int i = 0; i < count; i++) begin
            tbl[v].masks[tbl[v].nfr*12 +: 12] = m;
            tbl[v].nfr++;
        end
    endtask

    task automatic run_random(input int nframes);
        int          r, a, b;
        logic [11:0] m;
        logic [11:0] last_single;
        last_single = kmask(4);
        for (int i = 0; i < nframes; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                m = 12'd0;
            end else if (r < 8) begin
                if ($urandom_range(0, 1) == 1) begin
                    m = last_single;
                end else begin
                    m = kmask($urandom_range(0, 11));
                    last_single = m;
                end
            end else begin
                a = $urandom_range(0, 11);
                b = (a + 1 + $urandom_range(0, 10)) % 12;
                m = kmask(a) | kmask(b);
            end
            frame(m);
        end
    endtask

    initial begin
        int start_ev;

        for (int v = 0; v < 5; v++) begin
            tbl[v].nfr = 0; tbl[v].masks = '0; tbl[v].exp_n = 0; tbl[v].exp_code = 4'd0;
        end
        // '5' held 5 frames, then released
        add(0, kmask(4), 5);              add(0, 12'd0, 3);
        tbl[0].exp_n = 1; tbl[0].exp_code = 4'd5;
        // '#' held 3 frames
        add(1, kmask(11), 3);             add(1, 12'd0, 3);
        tbl[1].exp_n = 1; tbl[1].exp_code = 4'hB;
        // '8' bouncing
        add(2, kmask(7), 1); add(2, 12'd0, 1); add(2, kmask(7), 1); add(2, 12'd0, 3);
        tbl[2].exp_n = 0;
        // '1'+'3' together, then '1' alone
        add(3, kmask(0) | kmask(2), 4);   add(3, kmask(0), 2); add(3, 12'd0, 3);
        tbl[3].exp_n = 1; tbl[3].exp_code = 4'd1;
        // '2' then roll to '9' without release, then a clean '9'
        add(4, kmask(1), 2); add(4, kmask(8), 2); add(4, 12'd0, 2);
        add(4, kmask(8), 2); add(4, 12'd0, 3);
        tbl[4].exp_n = 2; tbl[4].exp_code = 4'd9;

        rst  = 1'b0;
        keys = 12'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        model_reset();
        row_frame();

        for (int v = 0; v < 5; v++) begin
            start_ev = ev_total;
            for (int f = 0; f < tbl[v].nfr; f++) frame(tbl[v].masks[f*12 +: 12]);
            check("tbl_events", 32'(ev_total - start_ev), 32'(tbl[v].exp_n));
            if (tbl[v].exp_n > 0) check("tbl_code", 32'(ev_last), 32'(tbl[v].exp_code));
            check("tbl_held_end", 32'(key_held), 32'd0);
        end

        run_random(80);
        repeat (4) frame(12'd0);

        // Reset in the middle of a '0' press: candidate discarded, no strobe.
        start_ev = ev_total;
        frame(kmask(10));
        keys = kmask(10);
        repeat (FRAME / 2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("midpress_reset");
        repeat (5) @(negedge clk);
        check_reset_outputs("midpress_hold");
        check("midpress_no_strobe", 32'(ev_total - start_ev), 32'd0);
        obs_q.delete();
        model_reset();
        keys = 12'd0;
        rst  = 1'b1;
        row_frame();
        start_ev = ev_total;
        frame(kmask(10));
        frame(kmask(10));
        repeat (3) frame(12'd0);
        check("after_reset_events", 32'(ev_total - start_ev), 32'd1);
        check("after_reset_code", 32'(ev_last), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
